// File: rtl/air_hockey_pkg.sv
// Shared screen geometry, colour constants and the packed pixel format
// used between the drawers, the write queue and the VGA adapter.
package air_hockey_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned COORD_W  = 11;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_GREEN = 3'b010;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } pixel_t;

    localparam int unsigned PIXEL_W = $bits(pixel_t);

    function automatic logic on_screen(
        input logic [COORD_W-1:0] x,
        input logic [COORD_W-1:0] y,
        input int unsigned        w,
        input int unsigned        h
    );
        return (x < COORD_W'(w)) && (y < COORD_W'(h));
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Single-clock synchronous FIFO with occupancy count; pushes are refused
// while full (no same-cycle pop bypass) and flush empties it.
module pixel_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 20
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push && reset_n && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pixel_write_queue.sv
// Clips drawer pixel writes to the screen, buffers them and drains them
// to the VGA adapter's x/y/colour/plot port whenever it permits.
module pixel_write_queue
    import air_hockey_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SCREEN_W = air_hockey_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = air_hockey_pkg::SCREEN_H
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [10:0]            in_x,
    input  logic [10:0]            in_y,
    input  logic [2:0]             in_colour,
    output logic                   in_ready,
    input  logic                   flush,
    input  logic                   out_enable,
    output logic [8:0]             vga_x,
    output logic [7:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic [$clog2(DEPTH):0] level,
    output logic [15:0]            clipped_count,
    output logic                   overflow
);

    logic               in_range;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    pixel_t             din;
    pixel_t             head;
    logic [PIXEL_W-1:0] dout_raw;

    assign in_range = on_screen(in_x, in_y, SCREEN_W, SCREEN_H);
    assign push     = in_valid && in_range && !fifo_full;
    assign pop      = out_enable && !fifo_empty;
    assign in_ready = !fifo_full;
    assign head     = pixel_t'(dout_raw);

    always_comb begin
        din        = '0;
        din.x      = in_x[8:0];
        din.y      = in_y[7:0];
        din.colour = in_colour;
    end

    pixel_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .din     (din),
        .dout    (dout_raw),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vga_x         <= '0;
            vga_y         <= '0;
            vga_colour    <= '0;
            vga_plot      <= 1'b0;
            clipped_count <= '0;
            overflow      <= 1'b0;
        end else if (flush) begin
            // Flush drops the pending plot and the presented pixel but keeps the clip tally.
            vga_plot <= 1'b0;
            overflow <= 1'b0;
        end else begin
            vga_plot <= pop;
            if (pop) begin
                vga_x      <= head.x;
                vga_y      <= head.y;
                vga_colour <= head.colour;
            end
            if (in_valid && !in_range && clipped_count != '1) begin
                clipped_count <= clipped_count + 16'd1;
            end
            if (in_valid && in_range && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_queue.sv
// Directed self-checking bench for pixel_write_queue: reset, plot latency,
// clipping, backpressure/overflow, concurrent push/pop, flush, saturation.
module tb_pixel_write_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [10:0] in_x;
    logic [10:0] in_y;
    logic [2:0]  in_colour;
    logic        in_ready;
    logic        flush;
    logic        out_enable;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [4:0]  level;
    logic [15:0] clipped_count;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pixel_write_queue #(
        .DEPTH    (16),
        .SCREEN_W (320),
        .SCREEN_H (240)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_colour     (in_colour),
        .in_ready      (in_ready),
        .flush         (flush),
        .out_enable    (out_enable),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .level         (level),
        .clipped_count (clipped_count),
        .overflow      (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int unsigned x, input int unsigned y, input logic [2:0] c);
        in_valid  = v;
        in_x      = 11'(x);
        in_y      = 11'(y);
        in_colour = c;
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        out_enable = 1'b0;
        drive(1'b0, 0, 0, 3'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        chk("rst_level", 32'(level), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_x", 32'(vga_x), 0);
        chk("rst_clip", 32'(clipped_count), 0);
        chk("rst_ovf", 32'(overflow), 0);

        // Single pixel: plot appears after the second edge
        out_enable = 1'b1;
        drive(1'b1, 8, 0, 3'b010);
        tick();
        drive(1'b0, 0, 0, 3'd0);
        chk("single_lvl1", 32'(level), 1);
        chk("single_noplot", 32'(vga_plot), 0);
        tick();
        chk("single_plot", 32'(vga_plot), 1);
        chk("single_x", 32'(vga_x), 8);
        chk("single_y", 32'(vga_y), 0);
        chk("single_col", 32'(vga_colour), 2);
        chk("single_lvl0", 32'(level), 0);
        tick();
        chk("single_plot_off", 32'(vga_plot), 0);
        chk("single_x_hold", 32'(vga_x), 8);

        // Clipping boundaries
        drive(1'b1, 320, 5, 3'd1);
        tick();
        drive(1'b1, 5, 240, 3'd1);
        tick();
        drive(1'b1, 2047, 2047, 3'd1);
        tick();
        drive(1'b0, 0, 0, 3'd0);
        chk("clip_noplot", 32'(vga_plot), 0);
        chk("clip_count", 32'(clipped_count), 3);
        chk("clip_level", 32'(level), 0);
        drive(1'b1, 319, 239, 3'b111);
        tick();
        drive(1'b0, 0, 0, 3'd0);
        tick();
        chk("edge_plot", 32'(vga_plot), 1);
        chk("edge_x", 32'(vga_x), 319);
        chk("edge_y", 32'(vga_y), 239);
        chk("edge_col", 32'(vga_colour), 7);
        tick();

        // Backpressure and overflow
        out_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i * 3, i, 3'(i));
            tick();
        end
        drive(1'b0, 0, 0, 3'd0);
        chk("bp_level16", 32'(level), 16);
        chk("bp_ready0", 32'(in_ready), 0);
        chk("bp_ovf0", 32'(overflow), 0);
        drive(1'b1, 100, 100, 3'd5);
        tick();
        drive(1'b0, 0, 0, 3'd0);
        chk("bp_ovf1", 32'(overflow), 1);
        chk("bp_level_hold", 32'(level), 16);
        out_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("bp_plot", 32'(vga_plot), 1);
            chk("bp_x", 32'(vga_x), 32'(i * 3));
            chk("bp_y", 32'(vga_y), 32'(i));
            chk("bp_col", 32'(vga_colour), 32'(i % 8));
        end
        tick();
        chk("bp_drained_plot", 32'(vga_plot), 0);
        chk("bp_drained_lvl", 32'(level), 0);
        chk("bp_ovf_sticky", 32'(overflow), 1);

        // Concurrent push/pop across the pointer wrap
        out_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 200 + i, 50 + i, 3'(i));
            tick();
        end
        chk("cc_preload", 32'(level), 5);
        out_enable = 1'b1;
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 205 + j, 55 + j, 3'(j + 5));
            tick();
            chk("cc_level", 32'(level), 5);
            chk("cc_plot", 32'(vga_plot), 1);
            chk("cc_x", 32'(vga_x), 32'(200 + j));
            chk("cc_y", 32'(vga_y), 32'(50 + j));
        end
        drive(1'b0, 0, 0, 3'd0);
        for (int j = 10; j < 15; j++) begin
            tick();
            chk("cc_drain_plot", 32'(vga_plot), 1);
            chk("cc_drain_x", 32'(vga_x), 32'(200 + j));
            chk("cc_drain_col", 32'(vga_colour), 32'(j % 8));
        end
        tick();
        chk("cc_empty", 32'(level), 0);

        // Flush with a concurrent push and pop
        out_enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10 + i, 20, 3'd3);
            tick();
        end
        chk("fl_preload", 32'(level), 8);
        chk("fl_ovf_pre", 32'(overflow), 1);
        flush = 1'b1;
        out_enable = 1'b1;
        drive(1'b1, 77, 77, 3'd6);
        tick();
        flush = 1'b0;
        drive(1'b0, 0, 0, 3'd0);
        chk("fl_level", 32'(level), 0);
        chk("fl_ovf", 32'(overflow), 0);
        chk("fl_plot", 32'(vga_plot), 0);
        chk("fl_clip", 32'(clipped_count), 3);
        chk("fl_ready", 32'(in_ready), 1);
        tick();
        tick();
        chk("fl_noplot", 32'(vga_plot), 0);
        chk("fl_level_after", 32'(level), 0);
        chk("fl_x_hold", 32'(vga_x), 214);

        // Clip counter saturation
        drive(1'b1, 400, 0, 3'd0);
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        drive(1'b0, 0, 0, 3'd0);
        chk("sat_clip", 32'(clipped_count), 32'hFFFF);
        chk("sat_level", 32'(level), 0);
        chk("sat_plot", 32'(vga_plot), 0);

        // Reset from a non-trivial state
        drive(1'b1, 5, 5, 3'd3);
        tick();
        drive(1'b1, 6, 6, 3'd3);
        tick();
        drive(1'b0, 0, 0, 3'd0);
        chk("pre_rst_plot", 32'(vga_plot), 1);
        chk("pre_rst_x", 32'(vga_x), 5);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst2_clip", 32'(clipped_count), 0);
        chk("rst2_plot", 32'(vga_plot), 0);
        chk("rst2_x", 32'(vga_x), 0);
        chk("rst2_y", 32'(vga_y), 0);
        chk("rst2_col", 32'(vga_colour), 0);
        chk("rst2_level", 32'(level), 0);
        chk("rst2_ovf", 32'(overflow), 0);
        chk("rst2_ready", 32'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_write_queue.md
Name: pixel_write_queue

Overview:
- Sits directly downstream of the rectangle drawing engines (boundary, puck and paddle drawers) and directly upstream of the VGA adapter.
- Accepts one 11-bit-coordinate pixel write per cycle and discards writes outside the 320x240 screen.
- Buffers in-range writes in a small FIFO and drains them to the adapter's narrow x/y/colour/plot interface whenever the adapter permits.
- Decouples drawer bursts from adapter pauses, such as frame-swap or erase windows.

Parameters:
- DEPTH, 16: FIFO entries; must be a power of 2, at least 2.
- SCREEN_W, 320: first illegal x coordinate.
- SCREEN_H, 240: first illegal y coordinate.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  pixel write request from a drawer (its writeEn).
- in_x  in  11  pixel x from drawer.
- in_y  in  11  pixel y from drawer.
- in_colour  in  3  pixel colour, RGB.
- in_ready  out  1  high when FIFO not full; advisory.
- flush  in  1  synchronous queue clear.
- out_enable  in  1  adapter permits a plot this cycle.
- vga_x  out  9  x to adapter.
- vga_y  out  8  y to adapter.
- vga_colour  out  3  colour to adapter.
- vga_plot  out  1  adapter write strobe.
- level  out  log2(DEPTH)+1  current occupancy.
- clipped_count  out  16  saturating count of off-screen writes.
- overflow  out  1  sticky flag: an in-range write was lost because the FIFO was full.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - Write pointer, read pointer and level go to 0.
  - vga_plot=0; vga_x, vga_y, vga_colour=0.
  - clipped_count=0, overflow=0.
  - After reset, in_ready=1.
- Push and clip:
  - Clip test: in_x>=SCREEN_W or in_y>=SCREEN_H means off-screen.
  - Off-screen write with in_valid=1: not stored; clipped_count increments, saturating at 16'hFFFF. FIFO fullness is irrelevant.
  - In-range write with in_valid=1 and FIFO not full: stored. The entry holds in_x[8:0], in_y[7:0] and in_colour.
  - In-range write with in_valid=1 and FIFO full: pixel is dropped and overflow is set.
  - There is no full-bypass: a pop in the same cycle does not make room for a push while full.
- in_ready = ~full, combinational from level.
- Pop: whenever out_enable=1 and the FIFO is not empty at a clock edge:
  - The head entry is removed.
  - vga_x, vga_y and vga_colour are loaded with the head entry.
  - vga_plot=1 for exactly that following cycle.
- When no pop occurs: vga_plot=0 and vga_x, vga_y, vga_colour hold their previous values.
- Latency: an in-range pixel presented at edge N into an empty FIFO, with out_enable=1, gives vga_plot=1 in the cycle after edge N+1. The output is 2 edges behind the input.
- Throughput: 1 pixel per cycle sustained while out_enable=1.
- Simultaneous push and pop while not full and not empty: level unchanged; both pointers advance.
- Ordering: strict FIFO; pixels reach the adapter in arrival order.
- Pointer arithmetic:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - level ranges 0..DEPTH.
  - full is level==DEPTH; empty is level==0.
- flush=1 at an edge:
  - Pointers and level go to 0, vga_plot=0 and overflow=0.
  - clipped_count is retained.
  - flush takes priority over a push and a pop in the same cycle; the pixel presented that cycle is discarded and not counted.
- Reset has priority over flush.
- Reset or flush mid-burst: the remaining entries are lost, with no partial plot. An upstream drawer mid-rectangle must be restarted by its controller.

Decomposition:
- Shared package air_hockey_pkg:
  - SCREEN_W=320, SCREEN_H=240, COORD_W=11.
  - Colour constants COLOUR_BLACK=3'b000, COLOUR_GREEN=3'b010, COLOUR_WHITE=3'b111.
  - Packed pixel typedef {x[8:0], y[7:0], colour[2:0]}, 20 bits.
- One sub-module, pixel_fifo: synchronous single-clock FIFO of 20-bit entries.
  - Ports: push, pop, din, dout, level, full, empty, flush.
- The parent module holds the clip logic, output registers, counters and the sticky flag.

Test Plan:
- Single pixel: in_x=8, in_y=0, colour 3'b010, out_enable=1 → two edges later vga_plot=1 for one cycle with vga_x=8, vga_y=0, vga_colour=010; level returns to 0.
- Clipping: writes (320,5), (5,240) and (2047,2047) → no vga_plot; clipped_count=3. Write (319,239) → plotted with vga_x=319, vga_y=239.
- Backpressure: out_enable=0, push 16 in-range pixels → level=16, in_ready=0. A 17th push → overflow=1, level stays 16. Raise out_enable → 16 plots in the original order, then vga_plot=0.
- Concurrent push/pop: preload 5 entries, then push and pop together for 10 cycles → level stays 5 and the output order matches input order across the pointer wrap.
- Flush: preload 8 entries with overflow set, assert flush together with in_valid → next cycle level=0, overflow=0, vga_plot=0; clipped_count unchanged; the flushed pixel is never plotted.
- Saturation and reset: drive 65540 off-screen writes → clipped_count=16'hFFFF. Then reset_n=0 for one edge → clipped_count=0, all outputs 0, in_ready=1.
